// File: rtl/hans_axil_pkg.sv
// Shared AXI4-Lite types and address helpers for the BRAM-backed memory slave.
package hans_axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axil_resp_t;

    // Byte address -> word index; strb_width is a power of two, so shift once per doubling.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input logic [63:0] offset,
                                               input int unsigned strb_width);
        logic [63:0] idx;
        idx = addr - offset;
        for (int unsigned w = 1; w < strb_width; w = w << 1)
            idx = idx >> 1;
        return idx;
    endfunction

endpackage

// File: rtl/bram_be_sdp.sv
// Simple-dual-port block RAM: byte-enabled write port, registered read port with enable.
// Written so the tools map it onto ECP5 DP16KD.
module bram_be_sdp #(
    parameter int    ADDR_W    = 4,
    parameter int    DATA_W    = 32,
    parameter int    STRB_W    = DATA_W / 8,
    parameter int    DEPTH     = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share one process so a same-cycle collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axil_bram_memory.sv
// AXI4-Lite slave over a byte-enable SDP block RAM; independent AW/W buffers, one B and one R in flight.
// Define AXIL_MEM_RANGE_CHECK_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axil_bram_memory
    import hans_axil_pkg::*;
#(
    parameter longint unsigned OFFSET       = 0,
    parameter int              ADDR_WIDTH   = 32,
    parameter int              DATA_WIDTH   = 32,
    parameter int              STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int              MEMORY_DEPTH = 119808,
    parameter string           INIT_FILE    = ""
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int RAM_AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    logic                  ready_en, aw_full, w_full, bvalid_q, rvalid_q, rd_err;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q, ram_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    axil_resp_t            bresp_q, rresp_q;
    logic [63:0]           widx, ridx;
    logic                  wr_oob, rd_oob;
    logic                  aw_hs, w_hs, ar_hs, commit;

    assign s_axil_awready = ready_en & ~aw_full;
    assign s_axil_wready  = ready_en & ~w_full;
    assign s_axil_arready = ready_en & (~rvalid_q | s_axil_rready);
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    // Gating keeps rdata at 0 out of reset and for rejected reads; the RAM register has no reset.
    assign s_axil_rdata   = (rvalid_q && !rd_err) ? ram_q : '0;

    assign aw_hs  = s_axil_awvalid & s_axil_awready;
    assign w_hs   = s_axil_wvalid & s_axil_wready;
    assign ar_hs  = s_axil_arvalid & s_axil_arready;
    assign commit = aw_full & w_full & (~bvalid_q | s_axil_bready);

    always_comb begin
        widx = word_index(64'(aw_addr_q), 64'(OFFSET), STRB_WIDTH);
        ridx = word_index(64'(s_axil_araddr), 64'(OFFSET), STRB_WIDTH);
    end

`ifdef AXIL_MEM_RANGE_CHECK_EN
    assign wr_oob = (64'(aw_addr_q) < 64'(OFFSET)) || (widx >= 64'(MEMORY_DEPTH));
    assign rd_oob = (64'(s_axil_araddr) < 64'(OFFSET)) || (ridx >= 64'(MEMORY_DEPTH));
`else
    assign wr_oob = 1'b0;
    assign rd_oob = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, widx, ridx};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en  <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_err    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                if (wr_oob) bresp_q <= SLVERR;
                else        bresp_q <= OKAY;
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rd_err   <= rd_oob;
                if (rd_oob) rresp_q <= SLVERR;
                else        rresp_q <= OKAY;
            end else if (s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    bram_be_sdp #(
        .ADDR_W    (RAM_AW),
        .DATA_W    (DATA_WIDTH),
        .STRB_W    (STRB_WIDTH),
        .DEPTH     (MEMORY_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (aclk),
        .we    (commit & ~wr_oob),
        .waddr (widx[RAM_AW-1:0]),
        .wdata (w_data_q),
        .wstrb (w_strb_q),
        .re    (ar_hs & ~rd_oob),
        .raddr (ridx[RAM_AW-1:0]),
        .rdata (ram_q)
    );

endmodule
